// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC pipeline control logic.
package wisc_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned INSTR_W = 16;

  // ADD R0,R0,R0: writes the hard-wired zero register, so it has no architectural effect.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StIwait = 2'd1,
    StDwait = 2'd2,
    StHalt  = 2'd3
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard and stall controller: load-use interlock, memory waits, branch squash, halt.
module hazard_unit #(
  parameter int unsigned REG_W = wisc_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_RegRd,
  input  logic [REG_W-1:0] IFID_RegRs,
  input  logic [REG_W-1:0] IFID_RegRt,
  input  logic             IFID_uses_rs,
  input  logic             IFID_uses_rt,
  input  logic             IFID_is_store,
  input  logic             branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             MEMWB_halt,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  import wisc_pkg::*;

  hz_state_t state_q, state_d;
  logic      flush_pending_q, flush_pending_d;
  logic      lu;

  // Store data on rt is forwarded MEM-to-MEM, so only the base register rs interlocks.
  assign lu = IDEX_MemRead && (IDEX_RegRd != '0) &&
              ((IFID_uses_rs && (IDEX_RegRd == IFID_RegRs)) ||
               (IFID_uses_rt && (IDEX_RegRd == IFID_RegRt) && !IFID_is_store));

  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    pc_stall        = 1'b0;
    ifid_stall      = 1'b0;
    ifid_flush      = 1'b0;
    idex_stall      = 1'b0;
    idex_bubble     = 1'b0;
    exmem_stall     = 1'b0;
    memwb_bubble    = 1'b0;
    halted          = 1'b0;

    if (rst_n) begin
      unique case (state_q)
        StRun: begin
          if (dmem_busy) begin
            {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble} = '1;
            state_d = StDwait;
          end else if (lu) begin
            {pc_stall, ifid_stall, idex_bubble} = '1;
          end else if (imem_busy) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
            state_d    = StIwait;
            if (branch_taken) flush_pending_d = 1'b1;
          end else begin
            ifid_flush = branch_taken;
          end
        end

        StIwait, StDwait: begin
          if (dmem_busy) begin
            {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble} = '1;
            state_d = StDwait;
            if (state_q == StIwait && branch_taken) flush_pending_d = 1'b1;
          end else if (imem_busy) begin
            pc_stall = 1'b1;
            state_d  = StIwait;
            if (branch_taken) flush_pending_d = 1'b1;
            if (lu) begin
              ifid_stall  = 1'b1;
              idex_bubble = 1'b1;
            end else begin
              ifid_flush = 1'b1;
            end
          end else begin
            // Fetch completed: squash the wrong-path word if a branch resolved meanwhile.
            state_d = StRun;
            if (lu) begin
              {pc_stall, ifid_stall, idex_bubble} = '1;
            end else begin
              ifid_flush      = flush_pending_q || branch_taken;
              flush_pending_d = 1'b0;
            end
          end
        end

        StHalt: begin
          {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble} = '1;
          halted = 1'b1;
        end

        default: state_d = StRun;
      endcase

      if (MEMWB_halt) state_d = StHalt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StRun;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(!rst_n),
    .inc  (pc_stall),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; a 3-bit-counter copy checks saturation.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       IDEX_MemRead;
  logic [3:0] IDEX_RegRd, IFID_RegRs, IFID_RegRt;
  logic       IFID_uses_rs, IFID_uses_rt, IFID_is_store;
  logic       branch_taken, imem_busy, dmem_busy, MEMWB_halt;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
  logic       exmem_stall, memwb_bubble, halted;
  logic [15:0] stall_cnt;
  logic       s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_bubble;
  logic       s_exmem_stall, s_memwb_bubble, s_halted;
  logic [2:0] s_stall_cnt;

  int tests  = 0;
  int failed = 0;

  // Output vector order: pc, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem, memwb, halted
  localparam logic [7:0] O_NONE = 8'h00;
  localparam logic [7:0] O_LU   = 8'hC8;
  localparam logic [7:0] O_IMIS = 8'hA0;
  localparam logic [7:0] O_FL   = 8'h20;
  localparam logic [7:0] O_ALL  = 8'hD6;
  localparam logic [7:0] O_HLT  = 8'hD7;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegRd(IDEX_RegRd),
    .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt),
    .IFID_uses_rs(IFID_uses_rs), .IFID_uses_rt(IFID_uses_rt), .IFID_is_store(IFID_is_store),
    .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .MEMWB_halt(MEMWB_halt),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_bubble(idex_bubble), .exmem_stall(exmem_stall),
    .memwb_bubble(memwb_bubble), .halted(halted), .stall_cnt(stall_cnt)
  );

  hazard_unit #(.REG_W(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegRd(IDEX_RegRd),
    .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt),
    .IFID_uses_rs(IFID_uses_rs), .IFID_uses_rt(IFID_uses_rt), .IFID_is_store(IFID_is_store),
    .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .MEMWB_halt(MEMWB_halt),
    .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
    .idex_stall(s_idex_stall), .idex_bubble(s_idex_bubble), .exmem_stall(s_exmem_stall),
    .memwb_bubble(s_memwb_bubble), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  task automatic clear_inputs();
    IDEX_MemRead = 1'b0; IDEX_RegRd = 4'd0; IFID_RegRs = 4'd0; IFID_RegRt = 4'd0;
    IFID_uses_rs = 1'b0; IFID_uses_rt = 1'b0; IFID_is_store = 1'b0;
    branch_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0; MEMWB_halt = 1'b0;
  endtask

  // Check the combinational outputs mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    #2;
    obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           exmem_stall, memwb_bubble, halted};
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    int sat;
    sat = (exp > 7) ? 7 : exp;
    tests++;
    assert (stall_cnt === 16'(exp)) else begin
      failed++;
      $error("FAIL %s: stall_cnt observed %0d expected %0d", tag, stall_cnt, exp);
    end
    tests++;
    assert (s_stall_cnt === 3'(sat)) else begin
      failed++;
      $error("FAIL %s_sat: stall_cnt observed %0d expected %0d", tag, s_stall_cnt, sat);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n      = 1'b0;
    dmem_busy  = 1'b1;
    MEMWB_halt = 1'b1;
    cyc("reset_outputs", O_NONE);
    chk_cnt("reset_cnt", 0);
    rst_n = 1'b1;
    clear_inputs();
    cyc("idle", O_NONE);

    // Load-use on rs: one bubble, then the load has moved on.
    IDEX_MemRead = 1'b1; IDEX_RegRd = 4'd3; IFID_RegRs = 4'd3; IFID_uses_rs = 1'b1;
    cyc("lu_rs", O_LU);
    IDEX_MemRead = 1'b0;
    cyc("lu_after", O_NONE);
    chk_cnt("lu_cnt", 1);

    // Store: data on rt exempt, base on rs not.
    IDEX_MemRead = 1'b1; IDEX_RegRd = 4'd3;
    IFID_RegRs = 4'd4; IFID_RegRt = 4'd3; IFID_uses_rs = 1'b1; IFID_uses_rt = 1'b1;
    IFID_is_store = 1'b1;
    cyc("st_rt_exempt", O_NONE);
    IFID_RegRs = 4'd3;
    cyc("st_rs_base", O_LU);
    IFID_RegRs = 4'd4; IFID_is_store = 1'b0;
    cyc("rt_nonstore", O_LU);
    chk_cnt("st_cnt", 3);

    // Load to R0 never interlocks.
    IDEX_RegRd = 4'd0; IFID_RegRs = 4'd0; IFID_RegRt = 4'd0;
    cyc("r0_dest", O_NONE);
    clear_inputs();

    branch_taken = 1'b1;
    cyc("run_branch", O_FL);
    IDEX_MemRead = 1'b1; IDEX_RegRd = 4'd5; IFID_RegRt = 4'd5; IFID_uses_rt = 1'b1;
    cyc("lu_beats_branch", O_LU);
    clear_inputs();
    chk_cnt("br_cnt", 4);

    // Imem miss with a branch resolving mid-wait: one extra flush on release.
    imem_busy = 1'b1;
    cyc("imiss_0", O_IMIS);
    branch_taken = 1'b1;
    cyc("imiss_1", O_IMIS);
    branch_taken = 1'b0;
    cyc("imiss_2", O_IMIS);
    imem_busy = 1'b0;
    cyc("imiss_release", O_FL);
    cyc("imiss_pending_clr", O_NONE);
    chk_cnt("imiss_cnt", 7);

    // Dmem wait overlapping an imem wait.
    dmem_busy = 1'b1; imem_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("dwait_%0d", i), O_ALL);
    dmem_busy = 1'b0;
    cyc("dwait_to_iwait", O_IMIS);
    cyc("iwait", O_IMIS);
    imem_busy = 1'b0;
    cyc("back_to_run", O_NONE);
    chk_cnt("dwait_cnt", 13);

    // Halt raised during an imem wait; held regardless of inputs.
    imem_busy = 1'b1;
    cyc("h_enter_iwait", O_IMIS);
    MEMWB_halt = 1'b1;
    @(posedge clk);
    #1;
    MEMWB_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dmem_busy    = i[0];
      imem_busy    = i[1];
      branch_taken = i[2];
      IDEX_MemRead = i[3];
      IDEX_RegRd   = 4'd2; IFID_RegRs = 4'd2; IFID_uses_rs = 1'b1;
      cyc($sformatf("halt_%0d", i), O_HLT);
    end
    chk_cnt("halt_cnt", 25);

    // Reset out of HALT.
    rst_n = 1'b0; MEMWB_halt = 1'b1; dmem_busy = 1'b1;
    cyc("rst_from_halt", O_NONE);
    chk_cnt("rst_cnt", 0);
    rst_n = 1'b1;
    clear_inputs();
    cyc("post_rst_idle", O_NONE);
    IDEX_MemRead = 1'b1; IDEX_RegRd = 4'd7; IFID_RegRs = 4'd7; IFID_uses_rs = 1'b1;
    cyc("post_rst_run_lu", O_LU);
    clear_inputs();
    chk_cnt("post_rst_cnt", 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
